// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID-stage issue/hazard bus between pipeline and hazard controller
interface pipe_hazard_ctrl_if #(
    parameter int RW = 3
);
    logic          id_valid;
    logic [2:0]    id_opcode;
    logic [RW-1:0] id_rd;
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic          flush;
    logic          halt_req;
    logic          stall;
    logic          bubble;
    logic          halt_ack;
    logic          busy;

    modport master (
        output id_valid, id_opcode, id_rd, id_rs1, id_rs2, flush, halt_req,
        input  stall, bubble, halt_ack, busy
    );

    modport slave (
        input  id_valid, id_opcode, id_rd, id_rs1, id_rs2, flush, halt_req,
        output stall, bubble, halt_ack, busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - RAW scoreboard issue controller with halt/drain; HAZ_PERF_EN adds perf counters
module pipe_hazard_ctrl #(
    parameter int RW     = 3,
    parameter int WB_LAT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    pipe_hazard_ctrl_if.slave     hz
`ifdef HAZ_PERF_EN
    ,
    output logic [15:0]           perf_stall_cnt,
    output logic [15:0]           perf_issue_cnt
`endif
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            run;
    logic            reads;
    logic            writes;
    logic            hazard;
    logic            issue;
    logic [WB_LAT-1:0] sb_v;
    logic [RW-1:0]   sb_rd [WB_LAT];

    always_comb begin
        reads  = 1'b0;
        writes = 1'b0;
        if (hz.id_valid) begin
            case (hz.id_opcode)
                3'b000, 3'b001: begin
                    reads  = 1'b1;
                    writes = 1'b1;
                end
                3'b010:  writes = 1'b1;
                default: ;
            endcase
        end
    end

    // Only older, in-flight entries are compared, so rd==rs of the same op is never a hazard.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            if (sb_v[i] && reads && (sb_rd[i] == hz.id_rs1 || sb_rd[i] == hz.id_rs2))
                hazard = 1'b1;
        end
    end

    assign issue     = hz.id_valid & ~hazard & run;
    assign hz.busy   = |sb_v;
    assign hz.stall  = ~run | (hz.id_valid & hazard);
    assign hz.bubble = hz.stall;

    always_ff @(posedge clk) begin
        if (!reset || hz.flush) begin
            sb_v <= '0;
        end else begin
            for (int i = 1; i < WB_LAT; i++)
                sb_v[i] <= sb_v[i-1];
            sb_v[0] <= issue & writes;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < WB_LAT; i++)
            sb_rd[i] <= sb_rd[i-1];
        sb_rd[0] <= hz.id_rd;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (hz.halt_req) state_nxt = DRAIN;
            DRAIN: begin
                if (!hz.halt_req)
                    state_nxt = RUN;
                else if (!hz.busy)
                    state_nxt = HALTED;
            end
            HALTED:  if (!hz.halt_req) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        run         = (state == RUN);
        hz.halt_ack = (state == HALTED);
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_issue_cnt <= '0;
        end else begin
            if (run && hz.id_valid && hazard && perf_stall_cnt != 16'hFFFF)
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            if (issue && perf_issue_cnt != 16'hFFFF)
                perf_issue_cnt <= perf_issue_cnt + 16'd1;
        end
    end
`endif
endmodule
